// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM state type,
// requester count / index width, and the index-to-one-hot helper used to
// build the grant vector from the 3-bit owner index.
package arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   // Decode a binary requester index into its one-hot grant vector.
   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh      = {NUM_REQ{1'b0}};
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority scan. Starting at ptr and wrapping 7->0,
// returns the first requester that is both requesting and not masked.
// found is low when no eligible requester exists (win_idx is then 0).
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic [NUM_REQ-1:0] mask,
   output logic               found,
   output logic [IDX_W-1:0]   win_idx
);

   logic [NUM_REQ-1:0] eligible_s;
   logic [IDX_W-1:0]   cand_s;

   assign eligible_s = req & mask;
   assign found      = |eligible_s;

   // Walk from the lowest priority slot up to ptr so the last hit wins.
   always_comb begin
      win_idx = {IDX_W{1'b0}};
      cand_s  = {IDX_W{1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_s  = ptr + IDX_W'(k);
         win_idx = eligible_s[cand_s] ? cand_s : win_idx;
      end
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with registered one-hot grant,
// binary owner index and valid flag. The owner keeps the grant while it
// holds its request; a new owner is chosen by scanning from the slot after
// the last owner. Hand-offs happen on a single edge with no idle bubble.
//
// Build option ARB_HOLD_LIMIT_EN: when defined, a hold counter forces the
// owner to yield after HOLD_MAX consecutive grant cycles if anyone else is
// requesting. When undefined, HOLD_MAX and CNT_W have no effect.
module rr_arbiter_8
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   state_e             state_r, state_s;
   logic [NUM_REQ-1:0] grant_r, grant_s;
   logic [IDX_W-1:0]   idx_r, idx_s;
   logic               valid_r, valid_s;
   logic [IDX_W-1:0]   ptr_r, ptr_s;

   logic               others_s;
   logic               limit_hit_s;
   logic [NUM_REQ-1:0] mask_s;
   logic               found_s;
   logic [IDX_W-1:0]   win_s;

   // Someone other than the current owner is asking for the resource.
   assign others_s = (req & ~idx_to_onehot(idx_r)) != {NUM_REQ{1'b0}};

`ifdef ARB_HOLD_LIMIT_EN
   logic [CNT_W-1:0] cnt_r, cnt_s;

   // Owner has used up its contended slot allowance.
   assign limit_hit_s = (state_r == OWN) && (cnt_r == CNT_W'(HOLD_MAX - 1)) && others_s;
`else
   logic [31:0] unused_cfg_s;

   assign unused_cfg_s = HOLD_MAX ^ CNT_W;
   assign limit_hit_s  = 1'b0;
`endif

   // A forced rotation must skip the current owner even though it still requests.
   assign mask_s = limit_hit_s ? ~idx_to_onehot(idx_r) : {NUM_REQ{1'b1}};

   rr_pick u_pick (
      .req     (req),
      .ptr     (ptr_r),
      .mask    (mask_s),
      .found   (found_s),
      .win_idx (win_s)
   );

   // Next-state and next-grant selection.
   always_comb begin
      state_s = state_r;
      grant_s = grant_r;
      idx_s   = idx_r;
      valid_s = valid_r;
      ptr_s   = ptr_r;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_s   = cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_s = OWN;
               grant_s = idx_to_onehot(win_s);
               idx_s   = win_s;
               valid_s = 1'b1;
               ptr_s   = win_s + IDX_W'(1);
`ifdef ARB_HOLD_LIMIT_EN
               cnt_s   = {CNT_W{1'b0}};
`endif
            end else begin
               state_s = IDLE;
            end
         end
         OWN: begin
            if (req[idx_r] && !limit_hit_s) begin
               state_s = OWN;
`ifdef ARB_HOLD_LIMIT_EN
               if (cnt_r != CNT_W'(HOLD_MAX - 1)) begin
                  cnt_s = cnt_r + CNT_W'(1);
               end else begin
                  cnt_s = cnt_r;
               end
`endif
            end else if (found_s) begin
               state_s = OWN;
               grant_s = idx_to_onehot(win_s);
               idx_s   = win_s;
               valid_s = 1'b1;
               ptr_s   = win_s + IDX_W'(1);
`ifdef ARB_HOLD_LIMIT_EN
               cnt_s   = {CNT_W{1'b0}};
`endif
            end else begin
               state_s = IDLE;
               grant_s = {NUM_REQ{1'b0}};
               idx_s   = {IDX_W{1'b0}};
               valid_s = 1'b0;
            end
         end
         default: begin
            state_s = IDLE;
            grant_s = {NUM_REQ{1'b0}};
            idx_s   = {IDX_W{1'b0}};
            valid_s = 1'b0;
         end
      endcase
   end

   // State, grant and pointer registers; reset clears the grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         grant_r <= {NUM_REQ{1'b0}};
         idx_r   <= {IDX_W{1'b0}};
         valid_r <= 1'b0;
         ptr_r   <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_s;
         grant_r <= grant_s;
         idx_r   <= idx_s;
         valid_r <= valid_s;
         ptr_r   <= ptr_s;
      end
   end

`ifdef ARB_HOLD_LIMIT_EN
   // Consecutive-grant counter for the current owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_s;
      end
   end
`endif

   assign grant       = grant_r;
   assign grant_idx   = idx_r;
   assign grant_valid = valid_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (HOLD_MAX=4). A behavioural model
// tracks owner / held-cycle count and is compared every cycle; directed
// vectors additionally check hand-computed literal expectations.
module tb_rr_arbiter_8;

   localparam int HM = 4;
`ifdef ARB_HOLD_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req   = 8'hFF;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;

   int checks   = 0;
   int failures = 0;

   rr_arbiter_8 #(.HOLD_MAX(HM), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit   m_valid;
   int   m_owner, m_start, m_held;
   bit   n_valid;
   int   n_owner, n_start, n_held;
   int   m_w;
   bit   m_lim;
   logic [7:0] exp_grant;
   logic [2:0] exp_idx;

   // First requesting index at or after 'start' (mod 8), skipping 'excl'.
   function automatic int pick(input logic [7:0] r, input int start, input int excl);
      int i;
      for (int k = 0; k < 8; k++) begin
         i = (start + k) % 8;
         if (i != excl && r[i]) return i;
      end
      return -1;
   endfunction

   always_comb begin
      n_valid = m_valid;
      n_owner = m_owner;
      n_start = m_start;
      n_held  = m_held;
      m_w     = -1;
      m_lim   = LIM && m_valid && (m_held >= HM) && ((req & ~(8'b0000_0001 << m_owner)) != 8'h00);
      if (m_valid && req[m_owner] && !m_lim) begin
         n_held = (m_held < HM) ? m_held + 1 : m_held;
      end else begin
         m_w = pick(req, m_start, m_lim ? m_owner : -1);
         if (m_w >= 0) begin
            n_valid = 1'b1;
            n_owner = m_w;
            n_start = (m_w + 1) % 8;
            n_held  = 1;
         end else begin
            n_valid = 1'b0;
            n_owner = 0;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_owner <= 0;
         m_start <= 0;
         m_held  <= 0;
      end else begin
         m_valid <= n_valid;
         m_owner <= n_owner;
         m_start <= n_start;
         m_held  <= n_held;
      end
   end

   always_comb begin
      exp_grant = m_valid ? (8'b0000_0001 << m_owner) : 8'h00;
      exp_idx   = 3'(m_owner);
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         checks++;
         if (grant !== exp_grant || grant_idx !== exp_idx || grant_valid !== m_valid) begin
            failures++;
            $display("FAIL model t=%0t got grant=%h idx=%0d valid=%b want grant=%h idx=%0d valid=%b",
                     $time, grant, grant_idx, grant_valid, exp_grant, exp_idx, m_valid);
         end
         checks++;
         if (!(grant == 8'h00 || $onehot(grant)) || grant_valid !== (grant != 8'h00)) begin
            failures++;
            $display("FAIL onehot t=%0t got grant=%h valid=%b", $time, grant, grant_valid);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic lit(input string name, input logic [7:0] eg, input logic [2:0] ei, input logic ev);
      checks++;
      if (grant !== eg || grant_idx !== ei || grant_valid !== ev) begin
         failures++;
         $display("FAIL %s got grant=%h idx=%0d valid=%b want grant=%h idx=%0d valid=%b",
                  name, grant, grant_idx, grant_valid, eg, ei, ev);
      end
   endtask

   task automatic cyc(input logic [7:0] r);
      req = r;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'hFF;
      repeat (2) @(negedge clk);
      lit("reset", 8'h00, 3'd0, 1'b0);
      rst_n = 1'b1;
      cyc(8'hFF);  lit("rst_release", 8'h01, 3'd0, 1'b1);

      cyc(8'h00);  lit("idle0", 8'h00, 3'd0, 1'b0);
      cyc(8'h20);  lit("single", 8'h20, 3'd5, 1'b1);
      cyc(8'h00);  lit("single_drop", 8'h00, 3'd0, 1'b0);

      // Park the pointer at 0 so fairness starts at requester 0.
      cyc(8'h80);  lit("prime7", 8'h80, 3'd7, 1'b1);
      cyc(8'h00);
      cyc(8'hFF);  lit("rr_0", 8'h01, 3'd0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         cyc(8'hFF & ~(8'b0000_0001 << ((k - 1) % 8)));
         lit("rr_seq", 8'b0000_0001 << (k % 8), 3'(k % 8), 1'b1);
      end

      // Wrap-around: last owner 6 leaves pointer at 7.
      cyc(8'h40);  lit("to6", 8'h40, 3'd6, 1'b1);
      cyc(8'h00);  lit("idle1", 8'h00, 3'd0, 1'b0);
      cyc(8'h41);  lit("wrap0", 8'h01, 3'd0, 1'b1);
      cyc(8'h40);  lit("wrap6", 8'h40, 3'd6, 1'b1);
      cyc(8'h00);

      // Hold limit with two constant requesters.
      for (int c = 0; c < 16; c++) begin
         cyc(8'h03);
         if (LIM) begin
            lit("hold_lim", ((c / 4) % 2) != 0 ? 8'h02 : 8'h01, 3'((c / 4) % 2), 1'b1);
         end else begin
            lit("hold_nolim", 8'h01, 3'd0, 1'b1);
         end
      end
      cyc(8'h00);  lit("idle2", 8'h00, 3'd0, 1'b0);

      // Saturated owner alone, then contention arrives.
      repeat (6) cyc(8'h02);
      lit("sat_alone", 8'h02, 3'd1, 1'b1);
      cyc(8'h03);
      lit("sat_contend", LIM ? 8'h01 : 8'h02, LIM ? 3'd0 : 3'd1, 1'b1);
      cyc(8'h00);

      // Reset mid-grant.
      cyc(8'h08);  lit("own3", 8'h08, 3'd3, 1'b1);
      #2 rst_n = 1'b0;
      #1 lit("async_clr", 8'h00, 3'd0, 1'b0);
      req = 8'h18;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      lit("post_reset", 8'h08, 3'd3, 1'b1);
      cyc(8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
